maze_cell_store: RTL and testbench

Owns the 16×16 maze cell memory (256 × 9-bit) and answers the player movement engine's BRAM interface:
- a registered read port addressed by `bram_addr`;
- a cell write port (`we_player`/`bram_addr_player`/`bram_din_player`) used to clear collectibles.

It also provides a second read port for the renderer and a request/ack spawn port for a collectible placer. It loads the maze from an external layout ROM after reset and keeps a live count of remaining collectibles.

---
 rtl/maze_cell_store.sv | 166 ++++++++++++++++
 tb/tb_maze_cell_store.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_cell_store.sv
`default_nettype none
// ==== maze_cell_store: 16x16 maze cell RAM with layout load, player/renderer reads,
// ==== player write port, collectible spawn port and live collectible count. Rev 1.0
module maze_cell_store #(
  parameter int CELLS = 256
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       rebuild,
  output logic       ready,
  output logic [7:0] init_addr,
  input  logic [8:0] init_data,
  input  logic [7:0] bram_addr,
  output logic [8:0] bram_dout,
  input  logic       we_player,
  input  logic [7:0] bram_addr_player,
  input  logic [8:0] bram_din_player,
  input  logic [7:0] render_addr,
  output logic [8:0] render_dout,
  input  logic       spawn_req,
  input  logic [7:0] spawn_addr,
  input  logic [2:0] spawn_type,
  output logic       spawn_ack,
  output logic       spawn_ok,
  output logic [8:0] collectibles_left,
  output logic       all_collected
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_READY = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] init_addr_q, init_addr_d;
  logic [8:0] count_q, count_d;
  logic [8:0] bram_dout_q, bram_dout_d;
  logic [8:0] render_dout_q, render_dout_d;
  logic       spawn_ack_q, spawn_ack_d;
  logic       spawn_ok_q, spawn_ok_d;

  logic [8:0] mem [CELLS];

  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [8:0] mem_wdata;
  logic       count_inc;
  logic       count_dec;
  logic [2:0] old_field;
  logic [3:0] spawn_cell;
  logic       spawn_place;
  logic       unused_hi;

  // Upper data bits are masked on every write path and never stored.
  assign unused_hi = ^{init_data[8:4], bram_din_player[8:4]};

  always_comb begin
    state_d       = state_q;
    init_addr_d   = init_addr_q;
    count_d       = count_q;
    bram_dout_d   = 9'd0;
    render_dout_d = 9'd0;
    spawn_ack_d   = 1'b0;
    spawn_ok_d    = spawn_ok_q;
    mem_we        = 1'b0;
    mem_waddr     = init_addr_q;
    mem_wdata     = 9'd0;
    count_inc     = 1'b0;
    count_dec     = 1'b0;
    old_field     = mem[bram_addr_player][3:1];
    spawn_cell    = mem[spawn_addr][3:0];
    spawn_place   = (spawn_cell == 4'd0) && (spawn_type >= 3'd1) && (spawn_type <= 3'd3);

    if (rebuild) begin
      state_d     = ST_INIT;
      init_addr_d = 8'd0;
      count_d     = 9'd0;
    end else begin
      case (state_q)
        ST_INIT: begin
          mem_we      = 1'b1;
          mem_waddr   = init_addr_q;
          mem_wdata   = {5'b0, init_data[3:0]};
          count_inc   = (init_data[3:1] != 3'd0);
          init_addr_d = init_addr_q + 8'd1;
          if (init_addr_q == 8'hff) begin
            state_d = ST_READY;
          end
        end
        ST_READY, ST_ACK: begin
          bram_dout_d   = mem[bram_addr];
          render_dout_d = mem[render_addr];
          if (state_q == ST_ACK) begin
            state_d = ST_READY;
          end
          // A player write always wins over a pending spawn.
          if (we_player) begin
            mem_we    = 1'b1;
            mem_waddr = bram_addr_player;
            mem_wdata = {5'b0, bram_din_player[3:0]};
            count_dec = (old_field != 3'd0) && (bram_din_player[3:1] == 3'd0);
            count_inc = (old_field == 3'd0) && (bram_din_player[3:1] != 3'd0);
          end else if ((state_q == ST_READY) && spawn_req) begin
            state_d     = ST_ACK;
            spawn_ack_d = 1'b1;
            spawn_ok_d  = spawn_place;
            if (spawn_place) begin
              mem_we    = 1'b1;
              mem_waddr = spawn_addr;
              mem_wdata = {5'b0, spawn_type, 1'b0};
              count_inc = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase

      if (count_inc && (count_q != 9'd256)) begin
        count_d = count_q + 9'd1;
      end else if (count_dec && (count_q != 9'd0)) begin
        count_d = count_q - 9'd1;
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_INIT;
      init_addr_q   <= 8'd0;
      count_q       <= 9'd0;
      bram_dout_q   <= 9'd0;
      render_dout_q <= 9'd0;
      spawn_ack_q   <= 1'b0;
      spawn_ok_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_addr_q   <= init_addr_d;
      count_q       <= count_d;
      bram_dout_q   <= bram_dout_d;
      render_dout_q <= render_dout_d;
      spawn_ack_q   <= spawn_ack_d;
      spawn_ok_q    <= spawn_ok_d;
    end
  end

  // Cell contents are deliberately not reset; the load rewrites every cell.
  always_ff @(posedge sysclk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign ready             = (state_q != ST_INIT);
  assign init_addr         = init_addr_q;
  assign bram_dout         = bram_dout_q;
  assign render_dout       = render_dout_q;
  assign spawn_ack         = spawn_ack_q;
  assign spawn_ok          = spawn_ok_q;
  assign collectibles_left = count_q;
  assign all_collected     = ready && (count_q == 9'd0);

endmodule
`default_nettype wire

// File: tb/tb_maze_cell_store.sv
`default_nettype none
// ==== tb_maze_cell_store: randomized bench with a cell-array reference model and
// ==== queue scoreboard for read data and spawn acknowledges. Rev 1.0
module tb_maze_cell_store;

  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       rebuild = 1'b0;
  logic       ready;
  logic [7:0] init_addr;
  logic [8:0] init_data;
  logic [7:0] bram_addr = 8'd0;
  logic [8:0] bram_dout;
  logic       we_player = 1'b0;
  logic [7:0] bram_addr_player = 8'd0;
  logic [8:0] bram_din_player = 9'd0;
  logic [7:0] render_addr = 8'd0;
  logic [8:0] render_dout;
  logic       spawn_req = 1'b0;
  logic [7:0] spawn_addr = 8'd0;
  logic [2:0] spawn_type = 3'd0;
  logic       spawn_ack;
  logic       spawn_ok;
  logic [8:0] collectibles_left;
  logic       all_collected;

  maze_cell_store #(.CELLS(256)) dut (
    .sysclk(sysclk), .reset(reset), .rebuild(rebuild), .ready(ready),
    .init_addr(init_addr), .init_data(init_data),
    .bram_addr(bram_addr), .bram_dout(bram_dout),
    .we_player(we_player), .bram_addr_player(bram_addr_player),
    .bram_din_player(bram_din_player),
    .render_addr(render_addr), .render_dout(render_dout),
    .spawn_req(spawn_req), .spawn_addr(spawn_addr), .spawn_type(spawn_type),
    .spawn_ack(spawn_ack), .spawn_ok(spawn_ok),
    .collectibles_left(collectibles_left), .all_collected(all_collected)
  );

  always #5 sysclk = ~sysclk;

  logic [8:0] rom [256];
  assign init_data = rom[init_addr];

  typedef struct { logic [8:0] b; logic [8:0] r; } rd_exp_t;
  typedef struct { int at_edge; bit ok; } ack_exp_t;
  rd_exp_t  rd_q[$];
  ack_exp_t ack_q[$];

  // Reference model: cell array plus load progress and handshake phase.
  logic [8:0] m_mem [256];
  int  m_loaded;
  bit  m_loading;
  bit  m_ready;
  bit  m_in_ack;
  bit  m_ok;
  int  m_count;

  int  n_checks = 0;
  int  n_err = 0;
  int  edge_n = 0;
  bit  rd_issue = 1'b0;
  bit  mon_en = 1'b0;
  bit  mon_iss;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int count_items();
    int c = 0;
    for (int i = 0; i < m_loaded; i++) begin
      if (m_mem[i][3:1] != 3'd0) c++;
    end
    return c;
  endfunction

  // Called at a falling edge with inputs already driven; predicts the next rising edge.
  task automatic cyc(input bit rd);
    bit ok;
    rd_exp_t e;
    if (rebuild) begin
      m_loading = 1'b1;
      m_loaded  = 0;
      m_in_ack  = 1'b0;
      m_ready   = 1'b0;
      rd_issue  = 1'b0;
    end else if (m_loading) begin
      chk("init_addr", init_addr, m_loaded);
      rd_issue = rd;
      if (rd) begin
        e.b = 9'd0; e.r = 9'd0;
        rd_q.push_back(e);
      end
      m_mem[m_loaded] = {5'b0, rom[m_loaded][3:0]};
      m_loaded++;
      if (m_loaded == 256) begin
        m_loading = 1'b0;
        m_ready   = 1'b1;
      end
      m_in_ack = 1'b0;
    end else begin
      rd_issue = rd;
      if (rd) begin
        e.b = m_mem[bram_addr]; e.r = m_mem[render_addr];
        rd_q.push_back(e);
      end
      if (we_player) begin
        m_mem[bram_addr_player] = {5'b0, bram_din_player[3:0]};
        m_in_ack = 1'b0;
      end else if (spawn_req && !m_in_ack) begin
        ok = (m_mem[spawn_addr][3:0] == 4'd0) && (spawn_type inside {3'd1, 3'd2, 3'd3});
        if (ok) m_mem[spawn_addr] = {5'b0, spawn_type, 1'b0};
        m_ok = ok;
        ack_q.push_back('{at_edge: edge_n + 1, ok: ok});
        m_in_ack = 1'b1;
      end else begin
        m_in_ack = 1'b0;
      end
    end
    m_count = count_items();
    @(negedge sysclk);
  endtask

  task automatic load_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      bram_addr        = 8'($urandom);
      render_addr      = 8'($urandom);
      we_player        = 1'($urandom);
      bram_addr_player = 8'($urandom);
      bram_din_player  = 9'($urandom);
      spawn_req        = 1'b0;
      cyc(1'($urandom));
    end
    we_player = 1'b0;
  endtask

  task automatic do_spawn(input logic [7:0] a, input logic [2:0] t);
    we_player  = 1'b0;
    spawn_req  = 1'b1;
    spawn_addr = a;
    spawn_type = t;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1);
      if (m_in_ack) break;
    end
    chk("spawn_ack_pulse_high", spawn_ack, 1);
    cyc(1'b1);
    chk("spawn_ack_pulse_low", spawn_ack, 0);
    spawn_req = 1'b0;
  endtask

  // Monitor: pops scoreboard entries as the DUT presents results.
  always begin
    @(posedge sysclk);
    edge_n++;
    mon_iss = rd_issue;
    #1;
    if (mon_en) begin
      chk("ready", ready, m_ready);
      chk("collectibles_left", collectibles_left, m_count);
      chk("all_collected", all_collected, m_ready && (m_count == 0));
      chk("spawn_ok_hold", spawn_ok, m_ok);
      if (ack_q.size() > 0 && ack_q[0].at_edge == edge_n) begin
        ack_exp_t a;
        a = ack_q.pop_front();
        chk("spawn_ack", spawn_ack, 1);
        chk("spawn_ok_at_ack", spawn_ok, a.ok);
      end else begin
        chk("spawn_ack_idle", spawn_ack, 0);
      end
      if (mon_iss) begin
        if (rd_q.size() == 0) begin
          chk("rd_queue_underflow", rd_q.size(), 1);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          chk("bram_dout", bram_dout, e.b);
          chk("render_dout", render_dout, e.r);
        end
      end
    end
  end

  task automatic model_reset_release();
    m_loading = 1'b1; m_loaded = 0; m_ready = 1'b0;
    m_in_ack = 1'b0; m_ok = 1'b0; m_count = 0;
  endtask

  initial begin
    logic [7:0] a;
    logic [8:0] r;
    logic [3:0] low;
    for (int i = 0; i < 256; i++) begin
      a   = 8'(i);
      r   = 9'($urandom);
      low = ((a[3:0] == 4'h0) || (a[3:0] == 4'hf) || (a[7:4] == 4'h0) || (a[7:4] == 4'hf) ||
             ($urandom_range(0, 7) == 0)) ? 4'h1 : 4'h0;
      rom[i] = {r[8:4], low};
    end
    rom[8'h22][3:0] = 4'h4;
    rom[8'h35][3:0] = 4'h2;
    rom[8'h47][3:0] = 4'h6;
    rom[8'h88][3:0] = 4'h3;
    rom[8'ha9][3:0] = 4'h4;
    rom[8'h55][3:0] = 4'h0;
    rom[8'h56][3:0] = 4'h0;
    rom[8'h57][3:0] = 4'h0;
    rom[8'h60][3:0] = 4'h0;

    repeat (3) @(negedge sysclk);
    chk("rst_ready", ready, 0);
    chk("rst_init_addr", init_addr, 0);
    chk("rst_bram_dout", bram_dout, 0);
    chk("rst_render_dout", render_dout, 0);
    chk("rst_spawn_ack", spawn_ack, 0);
    chk("rst_spawn_ok", spawn_ok, 0);
    chk("rst_count", collectibles_left, 0);
    chk("rst_all_collected", all_collected, 0);

    reset = 1'b0;
    model_reset_release();
    mon_en = 1'b1;
    load_cycles(256);
    chk("load_count", collectibles_left, 5);
    chk("load_ready", ready, 1);

    // Border cell and an item cell.
    bram_addr = 8'h00; render_addr = 8'h22;
    cyc(1'b1);
    chk("border_cell0", bram_dout, 9'h001);

    // Clear the type-2 item: read-first on the same address.
    we_player = 1'b1; bram_addr_player = 8'h22; bram_din_player = 9'h000; bram_addr = 8'h22;
    cyc(1'b1);
    chk("clear_count", collectibles_left, 4);
    chk("same_cycle_read_old", bram_dout, 9'h004);
    we_player = 1'b0;
    cyc(1'b1);
    chk("next_cycle_read_new", bram_dout, 9'h000);

    do_spawn(8'h55, 3'd3);
    chk("spawn_placed_ok", spawn_ok, 1);
    chk("spawn_placed_count", collectibles_left, 5);
    bram_addr = 8'h55;
    cyc(1'b1);
    chk("spawn_cell_value", bram_dout, 9'h006);

    do_spawn(8'h00, 3'd1);
    chk("spawn_wall_ok", spawn_ok, 0);
    do_spawn(8'h56, 3'd0);
    chk("spawn_type0_ok", spawn_ok, 0);
    chk("spawn_rejected_count", collectibles_left, 5);
    bram_addr = 8'h00; render_addr = 8'h56;
    cyc(1'b1);

    // Spawn starved by three back-to-back player writes.
    spawn_req = 1'b1; spawn_addr = 8'h57; spawn_type = 3'd1;
    we_player = 1'b1; bram_addr_player = 8'h60; bram_din_player = 9'h1f0;
    repeat (3) cyc(1'b1);
    do_spawn(8'h57, 3'd1);
    chk("starved_spawn_count", collectibles_left, 6);

    for (int n = 0; n < 600; n++) begin
      if (m_in_ack) begin
        spawn_req = 1'b0;
      end else if (!spawn_req && ($urandom_range(0, 3) == 0)) begin
        spawn_req  = 1'b1;
        spawn_addr = 8'($urandom);
        spawn_type = $urandom_range(0, 1) ? 3'($urandom_range(1, 3)) : 3'($urandom_range(0, 7));
      end
      we_player        = ($urandom_range(0, 9) < 3);
      bram_addr_player = 8'($urandom);
      bram_din_player  = 9'($urandom);
      bram_addr        = $urandom_range(0, 1) ? spawn_addr : 8'($urandom);
      render_addr      = 8'($urandom);
      cyc(1'b1);
    end
    spawn_req = 1'b0; we_player = 1'b0;
    cyc(1'b1);
    cyc(1'b1);

    for (int i = 0; i < 256; i++) begin
      if (m_mem[i][3:1] != 3'd0) begin
        we_player = 1'b1; bram_addr_player = 8'(i);
        bram_din_player = {5'h1f, 3'b000, m_mem[i][0]};
        bram_addr = 8'(i);
        cyc(1'b1);
      end
    end
    we_player = 1'b0;
    cyc(1'b1);
    chk("cleared_all_collected", all_collected, 1);
    chk("cleared_count", collectibles_left, 0);

    rebuild = 1'b1;
    cyc(1'b0);
    rebuild = 1'b0;
    chk("rebuild_ready_low", ready, 0);
    chk("rebuild_all_collected_low", all_collected, 0);
    load_cycles(120);
    rebuild = 1'b1;
    cyc(1'b0);
    rebuild = 1'b0;
    load_cycles(256);
    chk("reload_count", collectibles_left, 5);

    // Asynchronous reset in the middle of a load.
    rebuild = 1'b1;
    cyc(1'b0);
    rebuild = 1'b0;
    load_cycles(50);
    mon_en = 1'b0;
    rd_issue = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_rst_ready", ready, 0);
    chk("async_rst_init_addr", init_addr, 0);
    chk("async_rst_count", collectibles_left, 0);
    chk("async_rst_spawn_ok", spawn_ok, 0);
    chk("async_rst_bram_dout", bram_dout, 0);
    @(negedge sysclk);
    reset = 1'b0;
    model_reset_release();
    mon_en = 1'b1;
    load_cycles(256);
    chk("post_reset_count", collectibles_left, 5);
    for (int n = 0; n < 20; n++) begin
      bram_addr = 8'($urandom); render_addr = 8'($urandom);
      cyc(1'b1);
    end
    rd_issue = 1'b0;
    cyc(1'b0);
    chk("ack_queue_drained", ack_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
`default_nettype wire
